ssd1306_spi_tx: RTL

SSD1306_SPI_TX -- requirements
Module: ssd1306_spi_tx

---
 rtl/ssd1306_pkg.sv | 17 +
 rtl/ssd1306_spi_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ssd1306_pkg.sv
// Shared definitions for the SSD1306 SPI transmitter and its microcode executor.
package ssd1306_pkg;

  // SCK half-period, in clk_in cycles, used when the instantiating block does not override it.
  localparam int DEFAULT_SPI_HALF_PERIOD = 2;

  // Byte-level transmitter states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,  // CSN high, ready for a new byte
    S_LOW     = 3'd1,  // SCK low, MOSI stable for the coming rising edge
    S_HIGH    = 3'd2,  // SCK high, display samples MOSI
    S_END     = 3'd3,  // trailing SCK-low half-period after bit 0
    S_RELEASE = 3'd4,  // CSN high hold time before going idle
    S_ACTIVE  = 3'd5   // CSN held low between bytes of one command
  } spi_state_e;

endpackage

// File: rtl/ssd1306_spi_tx.sv
// SPI mode-0 byte transmitter for an SSD1306 display: one byte per trigger,
// MSB first, with optional chip-select release after the byte.
module ssd1306_spi_tx
  import ssd1306_pkg::*;
#(
  parameter int CLK_HALF_PERIOD = DEFAULT_SPI_HALF_PERIOD
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       tx_trigger_in,
  input  logic [7:0] data_in,
  input  logic       last_byte_in,
  output logic       ready_out,
  output logic       spi_sck_out,
  output logic       spi_mosi_out,
  output logic       spi_csn_out
);

  localparam int               DIV_W      = $clog2(CLK_HALF_PERIOD + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_HALF_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

  spi_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             csn_q, csn_d;
  logic             ready_q, ready_d;
  logic             div_done_s;

  // The current half-period ends when the down-counter has reached zero.
  assign div_done_s = (div_q == DIV_ZERO);

  // Next-state and next-output logic; every timed state reloads the divider on entry.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    last_d  = last_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    csn_d   = csn_q;
    ready_d = ready_q;
    case (state_q)
      S_IDLE, S_ACTIVE: begin
        if (tx_trigger_in) begin
          state_d = S_LOW;
          byte_d  = data_in;
          last_d  = last_byte_in;
          mosi_d  = data_in[7];
          bit_d   = 3'd0;
          csn_d   = 1'b0;
          ready_d = 1'b0;
          div_d   = DIV_RELOAD;
        end else begin
          state_d = state_q;
        end
      end
      S_LOW: begin
        if (div_done_s) begin
          state_d = S_HIGH;
          sck_d   = 1'b1;
          div_d   = DIV_RELOAD;
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end
      S_HIGH: begin
        if (div_done_s) begin
          sck_d = 1'b0;
          div_d = DIV_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = S_END;
          end else begin
            // MOSI moves on the same edge SCK falls, well ahead of the next rise.
            mosi_d  = byte_q[3'd6 - bit_q];
            bit_d   = bit_q + 3'd1;
            state_d = S_LOW;
          end
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end
      S_END: begin
        if (div_done_s) begin
          if (last_q) begin
            state_d = S_RELEASE;
            csn_d   = 1'b1;
            div_d   = DIV_RELOAD;
          end else begin
            state_d = S_ACTIVE;
            ready_d = 1'b1;
            div_d   = DIV_ZERO;
          end
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end
      S_RELEASE: begin
        if (div_done_s) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          div_d   = DIV_ZERO;
        end else begin
          div_d = div_q - DIV_ONE;
        end
      end
      default: begin
        // Unused encodings recover to a safe idle bus.
        state_d = S_IDLE;
        csn_d   = 1'b1;
        sck_d   = 1'b0;
        ready_d = 1'b1;
        div_d   = DIV_ZERO;
        bit_d   = 3'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset; a trigger during reset is discarded.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      div_q   <= DIV_ZERO;
      bit_q   <= 3'd0;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      csn_q   <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      csn_q   <= csn_d;
      ready_q <= ready_d;
    end
  end

  assign ready_out    = ready_q;
  assign spi_sck_out  = sck_q;
  assign spi_mosi_out = mosi_q;
  assign spi_csn_out  = csn_q;

endmodule
